// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter that shares the single FIFO write port among NREQ requesters.
// A bounded number of words per owner, same-cycle owner hand-off, and no writes while FULL.
module fifo_wr_arbiter #(
  parameter int NREQ  = 4,
  parameter int N     = 16,
  parameter int BURST = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NREQ-1:0]           req,
  input  logic [NREQ*N-1:0]         req_data,
  output logic [NREQ-1:0]           gnt,
  input  logic                      fifo_full,
  output logic                      fifo_we,
  output logic [N-1:0]              fifo_din,
  output logic [$clog2(NREQ)-1:0]   owner,
  output logic                      busy
);

  localparam int OW = $clog2(NREQ);
  localparam logic [3:0] BURST_L = 4'(BURST);

  typedef enum logic {
    S_IDLE,
    S_BURST
  } state_t;

  state_t          state, state_nx;
  logic [OW-1:0]   owner_nx;
  logic [3:0]      burst_cnt, cnt_nx;

  logic            found;
  logic [OW-1:0]   winner;
  logic [OW-1:0]   scan_idx;

  // Rotating-priority search: starts just after the current owner and wraps, so
  // the owner itself is examined last and can win only when it is the sole requester.
  always_comb begin
    found    = 1'b0;
    winner   = owner;
    scan_idx = owner;
    for (int i = 1; i <= NREQ; i++) begin
      scan_idx = OW'((int'(owner) + i) % NREQ);
      if (!found && req[scan_idx]) begin
        found  = 1'b1;
        winner = scan_idx;
      end
    end
  end

  // NOTE: every output of this block gets a default first, so no path through the
  // case/if tree leaves a variable unassigned and no latch is inferred.
  always_comb begin
    gnt      = '0;
    state_nx = state;
    owner_nx = owner;
    cnt_nx   = burst_cnt;
    if (!reset && !fifo_full) begin
      unique case (state)
        S_IDLE: begin
          if (found) begin
            gnt[winner] = 1'b1;
            owner_nx    = winner;
            cnt_nx      = 4'd1;
            state_nx    = (BURST == 1) ? S_IDLE : S_BURST;
          end
        end
        S_BURST: begin
          if (req[owner] && (burst_cnt < BURST_L)) begin
            gnt[owner] = 1'b1;
            cnt_nx     = burst_cnt + 4'd1;
          end else if (found) begin
            // Hand-off in the same cycle: no bubble between owners.
            gnt[winner] = 1'b1;
            owner_nx    = winner;
            cnt_nx      = 4'd1;
          end else begin
            state_nx = S_IDLE;
            cnt_nx   = 4'd0;
          end
        end
        default: begin
          state_nx = S_IDLE;
          cnt_nx   = 4'd0;
        end
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      owner     <= OW'(NREQ - 1);
      burst_cnt <= 4'd0;
    end else begin
      state     <= state_nx;
      owner     <= owner_nx;
      burst_cnt <= cnt_nx;
    end
  end

  always_comb begin
    fifo_din = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) fifo_din = req_data[i*N +: N];
    end
  end

  assign fifo_we = |gnt;
  assign busy    = (state == S_BURST) && !reset;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: stimulus queues expected writes tagged with their
// cycle number; a negedge monitor pops and compares every write the DUT performs.
module tb_fifo_wr_arbiter;

  localparam int NREQ  = 4;
  localparam int N     = 16;
  localparam int BURST = 4;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [NREQ-1:0]   req = '0;
  logic [NREQ*N-1:0] req_data;
  logic [NREQ-1:0]   gnt;
  logic              fifo_full = 1'b0;
  logic              fifo_we;
  logic [N-1:0]      fifo_din;
  logic [1:0]        owner;
  logic              busy;

  fifo_wr_arbiter #(.NREQ(NREQ), .N(N), .BURST(BURST)) dut (
    .clk      (clk),
    .reset    (reset),
    .req      (req),
    .req_data (req_data),
    .gnt      (gnt),
    .fifo_full(fifo_full),
    .fifo_we  (fifo_we),
    .fifo_din (fifo_din),
    .owner    (owner),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [3:0] gnt;
    logic [15:0] din;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  // Requesters present {id, sequence} and advance after each granted edge.
  logic [11:0] drv_seq [NREQ] = '{default: 12'd0};
  logic [11:0] exp_seq [NREQ] = '{default: 12'd0};

  always_comb begin
    for (int i = 0; i < NREQ; i++) req_data[i*N +: N] = {4'(i), drv_seq[i]};
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int i = 0; i < NREQ; i++) if (gnt[i]) drv_seq[i] <= drv_seq[i] + 12'd1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every write must match the next queued expectation, cycle included.
  always @(negedge clk) begin
    exp_t e;
    check("gnt_onehot_subset_of_req",
          32'($onehot0(gnt) && ((gnt & ~req) == '0)), 32'd1);
    if (fifo_we) begin
      if (sb.size() == 0) begin
        check("unexpected_write_gnt", 32'(gnt), 32'd0);
      end else begin
        e = sb.pop_front();
        check("write_cycle", 32'(cyc), 32'(e.cyc));
        check("write_gnt", 32'(gnt), 32'(e.gnt));
        check("write_din", 32'(fifo_din), 32'(e.din));
      end
    end else begin
      check("idle_din_zero", 32'(fifo_din), 32'd0);
      check("idle_gnt_zero", 32'(gnt), 32'd0);
    end
  end

  // One clock cycle: drive inputs, queue the hand-computed grant (0 = no write).
  task automatic step(input logic [3:0] r, input logic f, input logic [3:0] eg);
    exp_t e;
    req = r;
    fifo_full = f;
    if (eg != 4'd0) begin
      for (int i = 0; i < NREQ; i++) begin
        if (eg[i]) begin
          e.cyc = cyc;
          e.gnt = eg;
          e.din = {4'(i), exp_seq[i]};
          exp_seq[i] = exp_seq[i] + 12'd1;
        end
      end
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic [3:0] r);
    reset = 1'b1;
    req = r;
    fifo_full = 1'b0;
    #1;
    check("rst_gnt", 32'(gnt), 32'd0);
    check("rst_we", 32'(fifo_we), 32'd0);
    check("rst_din", 32'(fifo_din), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("post_rst_owner", 32'(owner), 32'd3);
    check("post_rst_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1);
  end

  initial begin
    logic [3:0] seq4 [5];
    seq4 = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

    repeat (2) @(posedge clk);
    #1;
    do_reset(4'b1111);

    // All requesters streaming: four beats each, rotating 0,1,2,3,0.
    for (int k = 0; k < 5; k++)
      for (int b = 0; b < BURST; b++) step(4'b1111, 1'b0, seq4[k]);
    check("stream_owner", 32'(owner), 32'd0);
    check("stream_busy", 32'(busy), 32'd1);

    // Sole requester re-owns after each burst with no gap.
    do_reset(4'b0000);
    for (int k = 0; k < 10; k++) begin
      step(4'b0100, 1'b0, 4'b0100);
      check("solo_busy", 32'(busy), 32'd1);
    end
    check("solo_owner", 32'(owner), 32'd2);
    step(4'b0000, 1'b0, 4'b0000);
    check("solo_drop_busy", 32'(busy), 32'd0);

    // Requester 0 abandons after two words; requester 1 takes over next cycle.
    do_reset(4'b0000);
    step(4'b0011, 1'b0, 4'b0001);
    step(4'b0011, 1'b0, 4'b0001);
    step(4'b0010, 1'b0, 4'b0010);
    check("handoff_owner", 32'(owner), 32'd1);
    step(4'b0011, 1'b0, 4'b0010);
    // Stall at burst_cnt=2: no writes, state held, then two more beats and rotate.
    for (int k = 0; k < 3; k++) begin
      step(4'b0011, 1'b1, 4'b0000);
      check("stall_owner", 32'(owner), 32'd1);
      check("stall_busy", 32'(busy), 32'd1);
    end
    step(4'b0011, 1'b0, 4'b0010);
    step(4'b0011, 1'b0, 4'b0010);
    step(4'b0011, 1'b0, 4'b0001);
    check("rotate_owner", 32'(owner), 32'd0);

    // Reset during owner 3's burst at burst_cnt=3.
    do_reset(4'b0000);
    for (int k = 0; k < 3; k++) step(4'b1000, 1'b0, 4'b1000);
    check("pre_rst_owner", 32'(owner), 32'd3);
    do_reset(4'b1111);
    step(4'b1111, 1'b0, 4'b0001);
    check("after_rst_owner", 32'(owner), 32'd0);
    step(4'b0000, 1'b0, 4'b0000);
    step(4'b0000, 1'b0, 4'b0000);

    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Round-robin write-port arbiter that shares the single write port of the team's synchronous FIFO (`top_FIFO`) among NREQ requesters. It selects one requester at a time and routes its data word and a write strobe to the FIFO `WE`/`D_IN` pins. It allows bounded bursts per owner and never writes while the FIFO reports `FULL`. It sits directly in front of the FIFO write side; the FIFO read side is untouched.

## Interface
- NREQ, 4, number of requesters (2..8)
- N, 16, data word width in bits (matches FIFO N)
- BURST, 4, max consecutive accepted words per owner before forced rotation (1..15)
- clk  input  1  rising-edge clock, shared with the FIFO
- reset  input  1  synchronous, active-high reset
- req  input  NREQ  req[i]=1: requester i holds a valid word
- req_data  input  NREQ*N  word of requester i on bits [i*N +: N]
- gnt  output  NREQ  one-hot grant; gnt[i]=1 means requester i's word is written at this rising edge
- fifo_full  input  1  FIFO FULL flag
- fifo_we  output  1  FIFO write enable (= |gnt)
- fifo_din  output  N  FIFO data in (= req_data slice of granted requester, 0 when no grant)
- owner  output  $clog2(NREQ)  index of current/last owner (registered)
- busy  output  1  1 while FSM is in BURST

## Operation
- FSM states: IDLE, BURST. Registered state: `state`, `owner`, `burst_cnt` (4 bits).
- Reset (reset=1 at an edge): state=IDLE, owner=NREQ-1, burst_cnt=0. While reset=1, gnt=0, fifo_we=0, fifo_din=0, busy=0 regardless of req.
- Rotating priority: search starts at (owner+1) mod NREQ and ascends with wrap; the first set req bit wins. After reset, requester 0 has top priority.
- IDLE: if fifo_full=0 and req≠0, gnt=winner combinationally. At the edge: owner←winner, burst_cnt←1, state←BURST, except when BURST=1: state stays IDLE.
- BURST: if req[owner]=1, fifo_full=0 and burst_cnt<BURST, then gnt[owner]=1 and burst_cnt increments at the edge.
- BURST exit, same cycle, no bubble:
  - Triggered when req[owner]=0 or burst_cnt=BURST.
  - Rotating-priority search runs from owner+1.
  - If a winner exists and fifo_full=0, grant it, owner←winner, burst_cnt←1.
  - Otherwise go to IDLE, burst_cnt←0.
  - A sole remaining requester may regain ownership immediately after its own burst expires.
- fifo_full=1 in any state: gnt=0, fifo_we=0. State, owner and burst_cnt hold, so a stalled burst resumes with its count intact.
- Requester protocol: hold req and req_data stable until gnt[i] is seen at an edge. After a granted edge, present the next word or drop req. Dropping req without a grant is allowed (abandon).
- gnt never has more than one bit set. gnt[i]=1 implies req[i]=1.
- The FIFO asserts FULL at M-1 stored words. The arbiter obeys the flag only and keeps no occupancy count.

## Timing
- Grant path is combinational from req/fifo_full/state to gnt/fifo_we/fifo_din in the same cycle: zero-cycle latency, one word per cycle max.
- Transfer completes at the rising edge where gnt[i]=1. The FIFO samples WE/D_IN at that same edge.
- Owner switch costs no idle cycle when another requester is pending.
- owner and busy update at the edge following the grant decision.
- reset asserted mid-burst: the next edge returns to IDLE/owner=NREQ-1. gnt is forced 0 in that cycle, so no write occurs.
- fifo_full rising mid-burst: gnt drops in the same cycle, and no word is lost or duplicated.

## Test plan
- Reset, then req=4'b1111 held with fifo_full=0, BURST=4: gnt=0001 for 4 cycles, then 0010×4, 0100×4, 1000×4, 0001×4. fifo_din matches each slice.
- Only req[2]=1 for 10 cycles: gnt=0100 every cycle (re-owned after each 4-beat burst), 10 FIFO writes, busy=1 throughout.
- req=4'b0011, requester 0 drops req after 2 grants: gnt switches to 0010 on the next cycle with no bubble, owner=1.
- fifo_full=1 for 3 cycles starting at burst_cnt=2 of owner 1: gnt=0 and fifo_we=0 for 3 cycles, then 2 more grants to requester 1 before rotation.
- reset pulsed during owner 3's burst at burst_cnt=3: next cycle gnt=0, owner=3 (NREQ-1), state IDLE. With req=1111, the first grant goes to requester 0.
- Integrated with `top_FIFO` (M=32), all requesters streaming, reader idle: writes stop exactly when FULL asserts (31 words). The drained sequence matches the arbitration order word for word.
